ls_wb_stage: RTL and testbench

LS_WB_STAGE -- requirements
Module: ls_wb_stage

---
 rtl/ls_wb_stage.sv | 157 +++++++++++++++
 tb/tb_ls_wb_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : ls_wb_stage
// Description : Load/store writeback stage. Accepts one op per cycle from EX,
//               waits for the memory response on loads, formats load data
//               (RV64 LB/LH/LW/LD and unsigned variants) and presents a
//               one-cycle registered commit to the register file.
//               Optional feature macro: LS_WB_FWD_EN adds fwd_valid/fwd_rd/
//               fwd_data forwarding ports mirroring the registered commit.
// Revision    : 1.0 - initial release
// ============================================================================
module ls_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_LS_valid,
  output logic        EX_LS_ready,
  input  logic [4:0]  EX_LS_rd,
  input  logic        EX_LS_dest_wen,
  input  logic        EX_LS_is_load,
  input  logic [2:0]  EX_LS_funct3,
  input  logic [2:0]  EX_LS_addr_low,
  input  logic [63:0] EX_LS_result,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        LS_WB_reg_ls_valid,
  output logic [4:0]  LS_WB_reg_rd,
  output logic        LS_WB_reg_dest_wen,
  output logic [63:0] write_data
`ifdef LS_WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [63:0] fwd_data
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_mem_done;

  // Fields of an accepted load, held until its memory response arrives
  logic [4:0]  r_pend_rd;
  logic        r_pend_wen;
  logic [2:0]  r_pend_funct3;
  logic [2:0]  r_pend_addr;

  // Registered commit values; they hold between strobes
  logic [4:0]  r_wb_rd;
  logic        r_wb_wen;
  logic [63:0] r_wb_data;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;
  logic [63:0] w_load_data;

  assign EX_LS_ready = (r_state != S_WAIT_MEM);
  assign w_accept    = EX_LS_valid & EX_LS_ready;
  // A response only counts while a load is actually outstanding
  assign w_mem_done  = (r_state == S_WAIT_MEM) & mem_rvalid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: COMMIT may chain straight into another op in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = EX_LS_is_load ? S_WAIT_MEM : S_COMMIT;
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        if (w_accept) w_next = EX_LS_is_load ? S_WAIT_MEM : S_COMMIT;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the op fields needed later when the load response returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_rd     <= 5'd0;
      r_pend_wen    <= 1'b0;
      r_pend_funct3 <= 3'd0;
      r_pend_addr   <= 3'd0;
    end else if (w_accept) begin
      r_pend_rd     <= EX_LS_rd;
      r_pend_wen    <= EX_LS_dest_wen;
      r_pend_funct3 <= EX_LS_funct3;
      r_pend_addr   <= EX_LS_addr_low;
    end
  end

  // Lane selection ignores address bits below the access size
  assign w_byte = mem_rdata[{r_pend_addr, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_pend_addr[2:1], 4'b0000} +: 16];
  assign w_word = mem_rdata[{r_pend_addr[2], 5'b00000} +: 32];

  // Sign/zero extension by funct3; the unused code 111 yields zero
  always_comb begin
    w_load_data = 64'd0;
    case (r_pend_funct3)
      3'b000:  w_load_data = {{56{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {56'd0, w_byte};
      3'b001:  w_load_data = {{48{w_half[15]}}, w_half};
      3'b101:  w_load_data = {48'd0, w_half};
      3'b010:  w_load_data = {{32{w_word[31]}}, w_word};
      3'b110:  w_load_data = {32'd0, w_word};
      3'b011:  w_load_data = mem_rdata;
      default: w_load_data = 64'd0;
    endcase
  end

  // Load the commit registers from either a non-load op or a load response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_rd   <= 5'd0;
      r_wb_wen  <= 1'b0;
      r_wb_data <= 64'd0;
    end else if (w_mem_done) begin
      r_wb_rd   <= r_pend_rd;
      r_wb_wen  <= r_pend_wen;
      r_wb_data <= w_load_data;
    end else if (w_accept && !EX_LS_is_load) begin
      r_wb_rd   <= EX_LS_rd;
      r_wb_wen  <= EX_LS_dest_wen;
      r_wb_data <= EX_LS_result;
    end
  end

  assign LS_WB_reg_ls_valid = (r_state == S_COMMIT);
  assign LS_WB_reg_rd       = r_wb_rd;
  assign LS_WB_reg_dest_wen = r_wb_wen;
  assign write_data         = r_wb_data;

`ifdef LS_WB_FWD_EN
  assign fwd_valid = LS_WB_reg_ls_valid & r_wb_wen;
  assign fwd_rd    = r_wb_rd;
  assign fwd_data  = r_wb_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ls_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ls_wb_stage
// Description : Self-checking bench for ls_wb_stage: directed vector table,
//               hand-written multi-cycle sequences and randomized traffic
//               compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        EX_LS_valid;
  logic        EX_LS_ready;
  logic [4:0]  EX_LS_rd;
  logic        EX_LS_dest_wen;
  logic        EX_LS_is_load;
  logic [2:0]  EX_LS_funct3;
  logic [2:0]  EX_LS_addr_low;
  logic [63:0] EX_LS_result;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        LS_WB_reg_ls_valid;
  logic [4:0]  LS_WB_reg_rd;
  logic        LS_WB_reg_dest_wen;
  logic [63:0] write_data;
`ifdef LS_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ls_wb_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .EX_LS_valid        (EX_LS_valid),
    .EX_LS_ready        (EX_LS_ready),
    .EX_LS_rd           (EX_LS_rd),
    .EX_LS_dest_wen     (EX_LS_dest_wen),
    .EX_LS_is_load      (EX_LS_is_load),
    .EX_LS_funct3       (EX_LS_funct3),
    .EX_LS_addr_low     (EX_LS_addr_low),
    .EX_LS_result       (EX_LS_result),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .LS_WB_reg_ls_valid (LS_WB_reg_ls_valid),
    .LS_WB_reg_rd       (LS_WB_reg_rd),
    .LS_WB_reg_dest_wen (LS_WB_reg_dest_wen),
    .write_data         (write_data)
`ifdef LS_WB_FWD_EN
    ,
    .fwd_valid          (fwd_valid),
    .fwd_rd             (fwd_rd),
    .fwd_data           (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [2:0]  addr;
    logic [63:0] rdata;
    logic [63:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    EX_LS_valid    = 1'b0;
    EX_LS_rd       = 5'd0;
    EX_LS_dest_wen = 1'b0;
    EX_LS_is_load  = 1'b0;
    EX_LS_funct3   = 3'd0;
    EX_LS_addr_low = 3'd0;
    EX_LS_result   = 64'd0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 64'd0;
  endtask

  task automatic drive_op(input logic ld, input logic [2:0] f3, input logic [2:0] a,
                          input logic [63:0] res, input logic [4:0] rd, input logic wen);
    EX_LS_valid    = 1'b1;
    EX_LS_is_load  = ld;
    EX_LS_funct3   = f3;
    EX_LS_addr_low = a;
    EX_LS_result   = res;
    EX_LS_rd       = rd;
    EX_LS_dest_wen = wen;
  endtask

  // Reference load formatter: access size from funct3, naturally aligned offset
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] a,
                                           input logic [63:0] d);
    int size;
    int off;
    logic [63:0] v;
    logic [63:0] mask;
    if (f3 == 3'b111) return 64'd0;
    size = 1 << f3[1:0];
    if (size == 8) return d;
    off  = (int'(a) / size) * size;
    mask = (64'd1 << (8 * size)) - 64'd1;
    v    = (d >> (8 * off)) & mask;
    if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  // Reference model state: visible outputs plus the outstanding load
  logic        m_wait, m_commit, m_wen, p_wen;
  logic [4:0]  m_rd, p_rd;
  logic [63:0] m_data;
  logic [2:0]  p_f3, p_addr;

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    // Asynchronous reset takes effect before any clock edge
    chk("reset_strobe", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
    chk("reset_rd",     {59'd0, LS_WB_reg_rd}, 64'd0);
    chk("reset_wen",    {63'd0, LS_WB_reg_dest_wen}, 64'd0);
    chk("reset_data",   write_data, 64'd0);
    chk("reset_ready",  {63'd0, EX_LS_ready}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_ready",  {63'd0, EX_LS_ready}, 64'd1);
    chk("post_reset_strobe", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

    //                 ld    f3      addr    rdata                   result                  rd     wen   expected
    vecs[0]  = '{1'b0, 3'd0, 3'd0, 64'd0,                 64'h1234,               5'd5,  1'b1, 64'h1234};
    vecs[1]  = '{1'b1, 3'd0, 3'd3, 64'h0000_0000_8000_0000, 64'd0,               5'd6,  1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[2]  = '{1'b1, 3'd5, 3'd6, 64'hBEEF_0000_0000_0000, 64'd0,               5'd7,  1'b1, 64'h0000_0000_0000_BEEF};
    vecs[3]  = '{1'b1, 3'd2, 3'd4, 64'hBEEF_0000_0000_0000, 64'd0,               5'd8,  1'b1, 64'hFFFF_FFFF_BEEF_0000};
    vecs[4]  = '{1'b1, 3'd4, 3'd7, 64'hAB00_0000_0000_0000, 64'd0,               5'd9,  1'b1, 64'h0000_0000_0000_00AB};
    vecs[5]  = '{1'b1, 3'd1, 3'd3, 64'h0000_0000_8001_0000, 64'd0,               5'd10, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
    vecs[6]  = '{1'b1, 3'd6, 3'd7, 64'hDEAD_BEEF_0000_0001, 64'd0,               5'd11, 1'b0, 64'h0000_0000_DEAD_BEEF};
    vecs[7]  = '{1'b1, 3'd3, 3'd5, 64'h0123_4567_89AB_CDEF, 64'd0,               5'd12, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[8]  = '{1'b1, 3'd7, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,               5'd13, 1'b1, 64'd0};
    vecs[9]  = '{1'b1, 3'd0, 3'd0, 64'h0000_0000_0000_007F, 64'd0,               5'd14, 1'b1, 64'h0000_0000_0000_007F};
    vecs[10] = '{1'b0, 3'd0, 3'd0, 64'd0,                 64'hFFFF_0000_FFFF_0000, 5'd0, 1'b0, 64'hFFFF_0000_FFFF_0000};

    foreach (vecs[i]) begin
      chk("vec_ready_idle", {63'd0, EX_LS_ready}, 64'd1);
      drive_op(vecs[i].is_load, vecs[i].f3, vecs[i].addr, vecs[i].result, vecs[i].rd, vecs[i].wen);
      step();
      idle_inputs();
      if (vecs[i].is_load) begin
        chk("vec_wait_strobe", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
        chk("vec_wait_ready",  {63'd0, EX_LS_ready}, 64'd0);
        step();
        chk("vec_wait_ready2", {63'd0, EX_LS_ready}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = vecs[i].rdata;
        step();
        mem_rvalid = 1'b0;
      end
      chk("vec_strobe", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
      chk("vec_rd",     {59'd0, LS_WB_reg_rd}, {59'd0, vecs[i].rd});
      chk("vec_wen",    {63'd0, LS_WB_reg_dest_wen}, {63'd0, vecs[i].wen});
      chk("vec_data",   write_data, vecs[i].exp);
      step();
      chk("vec_strobe_drop", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
      chk("vec_data_hold",   write_data, vecs[i].exp);
    end

    // Back-to-back non-loads, one per cycle
    drive_op(1'b0, 3'd0, 3'd0, 64'hAAAA, 5'd3, 1'b1);
    step();
    chk("b2b_ready", {63'd0, EX_LS_ready}, 64'd1);
    chk("b2b_strobe1", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
    chk("b2b_data1", write_data, 64'hAAAA);
    drive_op(1'b0, 3'd0, 3'd0, 64'hBBBB, 5'd4, 1'b1);
    step();
    idle_inputs();
    chk("b2b_strobe2", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
    chk("b2b_rd2", {59'd0, LS_WB_reg_rd}, 64'd4);
    chk("b2b_data2", write_data, 64'hBBBB);
    step();
    chk("b2b_end", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

    // Spurious response while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555;
    step();
    mem_rvalid = 1'b0;
    chk("spurious_strobe", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
    chk("spurious_data", write_data, 64'hBBBB);
    step();
    chk("spurious_strobe2", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

`ifdef LS_WB_FWD_EN
    drive_op(1'b0, 3'd0, 3'd0, 64'hC0DE, 5'd9, 1'b0);
    step();
    chk("fwd_nowen_strobe", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
    chk("fwd_nowen_valid", {63'd0, fwd_valid}, 64'd0);
    drive_op(1'b0, 3'd0, 3'd0, 64'hF00D, 5'd17, 1'b1);
    step();
    idle_inputs();
    chk("fwd_valid", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_rd", {59'd0, fwd_rd}, 64'd17);
    chk("fwd_data", fwd_data, 64'hF00D);
    step();
    chk("fwd_valid_drop", {63'd0, fwd_valid}, 64'd0);
`endif

    // Reset while a load is outstanding discards it
    drive_op(1'b1, 3'd3, 3'd0, 64'd0, 5'd21, 1'b1);
    step();
    idle_inputs();
    chk("rstwait_ready", {63'd0, EX_LS_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait_ready_async", {63'd0, EX_LS_ready}, 64'd1);
    chk("rstwait_data_async", write_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    step();
    mem_rvalid = 1'b0;
    chk("rstwait_strobe", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
    chk("rstwait_rd", {59'd0, LS_WB_reg_rd}, 64'd0);
    chk("rstwait_wen", {63'd0, LS_WB_reg_dest_wen}, 64'd0);
    chk("rstwait_data", write_data, 64'd0);

    // Randomized traffic against the reference model
    m_wait = 1'b0; m_commit = 1'b0; m_rd = 5'd0; m_wen = 1'b0; m_data = 64'd0;
    p_rd = 5'd0; p_wen = 1'b0; p_f3 = 3'd0; p_addr = 3'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk("rnd_strobe", {63'd0, LS_WB_reg_ls_valid}, {63'd0, m_commit});
      chk("rnd_ready",  {63'd0, EX_LS_ready}, {63'd0, !m_wait});
      chk("rnd_rd",     {59'd0, LS_WB_reg_rd}, {59'd0, m_rd});
      chk("rnd_wen",    {63'd0, LS_WB_reg_dest_wen}, {63'd0, m_wen});
      chk("rnd_data",   write_data, m_data);
      EX_LS_valid    = ($urandom_range(2, 0) != 0);
      EX_LS_rd       = 5'($urandom);
      EX_LS_dest_wen = 1'($urandom);
      EX_LS_is_load  = 1'($urandom);
      EX_LS_funct3   = 3'($urandom);
      EX_LS_addr_low = 3'($urandom);
      EX_LS_result   = {$urandom, $urandom};
      mem_rvalid     = ($urandom_range(2, 0) == 0);
      mem_rdata      = {$urandom, $urandom};
      m_commit = 1'b0;
      if (m_wait) begin
        if (mem_rvalid) begin
          m_commit = 1'b1;
          m_wait   = 1'b0;
          m_rd     = p_rd;
          m_wen    = p_wen;
          m_data   = ref_load(p_f3, p_addr, mem_rdata);
        end
      end else if (EX_LS_valid) begin
        if (EX_LS_is_load) begin
          m_wait = 1'b1;
          p_rd   = EX_LS_rd;
          p_wen  = EX_LS_dest_wen;
          p_f3   = EX_LS_funct3;
          p_addr = EX_LS_addr_low;
        end else begin
          m_commit = 1'b1;
          m_rd     = EX_LS_rd;
          m_wen    = EX_LS_dest_wen;
          m_data   = EX_LS_result;
        end
      end
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
